// File: rtl/hamming_tx_sequencer.sv
// hamming_tx_sequencer: serial nibble in, 7,4 Hamming encode, FIFO queue, serial codeword out with handshakes
module hamming_tx_sequencer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        s_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_first,
    output logic                        out_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_WIDTH-1:0]        cw_count,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state_q;
    logic [1:0]         in_cnt_q;
    logic [2:0]         nib_q;
    logic [6:0]         fifo_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        level_q;
    logic [6:0]         sh_q;
    logic [2:0]         out_cnt_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]         d;
    logic [6:0]         cw, head;
    logic               full, xfer, last_xfer, push, pop;
    always_comb begin
        d         = {nib_q, s_in};
        cw        = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
        full      = level_q == (AW+1)'(FIFO_DEPTH);
        xfer      = state_q == SHIFT && out_ready;
        last_xfer = xfer && out_cnt_q == 3'd6;
        // when full, the only possible pop is the reload on the last bit transfer
        in_ready  = !(in_cnt_q == 2'd3 && full && !last_xfer);
        push      = in_valid && in_ready && in_cnt_q == 2'd3;
        // reload after a codeword may take the codeword pushed on the same edge
        pop       = state_q == IDLE ? level_q != '0 : last_xfer && (level_q != '0 || push);
        head      = level_q == '0 ? cw : fifo_q[rd_q];
        out_valid = state_q == SHIFT;
        s_out     = sh_q[6];
        out_first = out_valid && out_cnt_q == 3'd0;
        out_last  = out_valid && out_cnt_q == 3'd6;
        fifo_level = level_q;
        cw_count  = cnt_q;
        busy      = in_cnt_q != 2'd0 || level_q != '0 || state_q == SHIFT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            nib_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            sh_q      <= '0;
            out_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (in_valid && in_ready) begin
                in_cnt_q <= in_cnt_q + 2'd1;
                nib_q    <= {nib_q[1:0], s_in};
            end
            if (push) begin
                fifo_q[wr_q] <= cw;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                sh_q      <= head;
                out_cnt_q <= '0;
                state_q   <= SHIFT;
            end else if (xfer) begin
                sh_q      <= sh_q << 1;
                out_cnt_q <= out_cnt_q + 3'd1;
                if (out_cnt_q == 3'd6) state_q <= IDLE;
            end
            if (last_xfer) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: doc/hamming_tx_sequencer.md
Name: hamming_tx_sequencer

Overview:
Single-clock controller that sequences the 7,4 Hamming transmit path. It accepts a serial data stream under a valid/ready handshake and assembles nibbles. Each nibble is encoded into a 7-bit codeword, and codewords are queued in a small FIFO. Codewords are shifted out serially under a second valid/ready handshake. The block sits between the serial source and the line/serial sink and replaces the free-running two-clock encoder arrangement with explicit flow control.

Parameters:
FIFO_DEPTH, 2, codeword FIFO entries; power of two, >= 2
CNT_WIDTH, 16, width of the transmitted-codeword counter

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_in  input  1  serial data bit
in_valid  input  1  s_in valid this cycle
in_ready  output  1  block accepts s_in this cycle
s_out  output  1  serial codeword bit
out_valid  output  1  s_out valid this cycle
out_ready  input  1  sink accepts s_out this cycle
out_first  output  1  s_out is codeword bit 6, the first bit sent
out_last  output  1  s_out is codeword bit 0, the last bit sent
fifo_level  output  $clog2(FIFO_DEPTH)+1  queued codewords
cw_count  output  CNT_WIDTH  codewords fully transmitted; wraps modulo 2^CNT_WIDTH
busy  output  1  partial nibble held, FIFO non-empty, or shifter active

Behaviour:
- Reset (synchronous, reset=1 at an edge) clears:
  - input bit counter and nibble register
  - FIFO pointers; fifo_level=0
  - shifter and FSM, to IDLE
  - cw_count=0
- Reset values: out_valid=0, out_first=0, out_last=0, s_out=0, busy=0, in_ready=1.
- Reset mid-operation discards partial nibbles, queued codewords and any partially sent codeword. There is no completion of in-flight data.
- Input transfer: in_valid && in_ready at an edge. Bits arrive MSB first: 1st accepted bit = d3, 2nd = d2, 3rd = d1, 4th = d0. in_cnt counts 0..3 and wraps.
- Encoding: p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3. Codeword cw[6:0] = {d3,d2,d1,p3,d0,p2,p1}.
- Push timing: the codeword is encoded combinationally from the three held bits plus the 4th incoming bit. It is pushed into the FIFO on the same edge that accepts the 4th bit.
- in_ready = !(in_cnt==3 && FIFO full && !pop_this_cycle). Bits 1-3 are always accepted. A simultaneous pop frees the slot, so the 4th bit is accepted.
- Output FSM states: IDLE, SHIFT.
  - IDLE: if FIFO non-empty, pop the head into the shifter at the edge, set out_cnt=0, go to SHIFT.
  - SHIFT: out_valid=1, s_out = shifter bit (6 - out_cnt), out_first = (out_cnt==0), out_last = (out_cnt==6).
  - Bit transfer (out_valid && out_ready): out_cnt increments.
  - On the transfer with out_cnt==6: cw_count increments. If the FIFO is non-empty (after the same-edge push), pop and reload with no bubble and stay in SHIFT; otherwise go to IDLE.
- Backpressure: out_ready=0 holds s_out, out_first, out_last and out_cnt stable. out_valid never drops mid-codeword.
- Latency: 4th bit accepted at edge E0 with the FSM idle and FIFO empty → popped at E1 → out_valid=1 and first bit on s_out in the cycle after E1.
- Simultaneous push and pop: fifo_level unchanged. A push into an empty FIFO is not visible to IDLE until the next edge, so no same-edge bypass.
- fifo_level never exceeds FIFO_DEPTH and never underflows.
- Pointers wrap modulo FIFO_DEPTH.
- busy = (in_cnt!=0) || (fifo_level!=0) || (state==SHIFT).

Test Plan:
- Reset, then nibble 1011 with in_valid=1 continuous and out_ready=1 → cw=7'h55.
  - s_out sequence 1,0,1,0,1,0,1.
  - out_first on bit 1, out_last on bit 7.
  - out_valid first high 2 cycles after the 4th accept edge.
  - cw_count=1; busy=0 afterwards.
- Nibbles 1111, 0000, 1001 with out_ready=1 → 7'h7F, 7'h00, 7'h4C sent back-to-back with no out_valid gap between codewords; cw_count=3.
- out_ready=0 throughout, 16 bits offered:
  - FIFO fills, fifo_level=2, shifter holds the first codeword.
  - in_ready drops while in_cnt==3.
  - Raise out_ready → all three codewords drain in order and the held 4th bit is then accepted.
- Toggle out_ready 1/0 every cycle on nibble 1011 → s_out bits identical to scenario 1; out_valid stays high for all 14 cycles.
- in_valid gapped (1 bit every 3 cycles), nibble 1001 → single codeword 7'h4C; no push before the 4th bit.
- Assert reset during output bit 3 of 7'h55 with one codeword queued → next cycle out_valid=0, fifo_level=0, cw_count=0, busy=0; a subsequent nibble 0000 yields 7'h00.
